// File: rtl/filter_pkg.sv
// Definitions shared between the 3x3 window generator and the median filter core.
package filter_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned WIN_TAPS   = 9;

  // Tap order of a window: row-major, oldest line first, oldest column first
  localparam int unsigned W_TL = 0;
  localparam int unsigned W_TC = 1;
  localparam int unsigned W_TR = 2;
  localparam int unsigned W_ML = 3;
  localparam int unsigned W_MC = 4;
  localparam int unsigned W_MR = 5;
  localparam int unsigned W_BL = 6;
  localparam int unsigned W_BC = 7;
  localparam int unsigned W_BR = 8;

endpackage

// File: rtl/line_buf.sv
// One image line of pixel storage, indexed by column.
// The read port is combinational, so a read and a write to the same column in the same cycle
// return the old contents (read-before-write).
module line_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; every location is rewritten before it matters.
  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Write the accepted column value at the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the median filter core.
// Takes a raster-order pixel stream and emits every full interior 3x3 window, registered,
// one cycle after the pixel that completes it is accepted.
module median_window_gen
  import filter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [WIN_TAPS*DATA_W-1:0] out_win
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned WW = WIN_TAPS * DATA_W;

  typedef logic [DATA_W-1:0] pix_t;

  logic [CW-1:0] col, c_cur;
  logic [RW-1:0] row, r_cur;
  logic          accept;
  logic          emit;
  logic          frame_end;
  pix_t          lb1_rd, lb2_rd;
  pix_t          top_sr [3];
  pix_t          mid_sr [3];
  pix_t          bot_sr [3];
  logic [WW-1:0] win_nx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Line buffers: lb1 holds the previous line, lb2 the one before it.
  line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (c_cur),
    .wdata (in_data),
    .rdata (lb1_rd)
  );

  line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (c_cur),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  // Position of the current pixel, emit decision and the window as it will look after the shift.
  always_comb begin
    c_cur     = in_sof ? '0 : col;
    r_cur     = in_sof ? '0 : row;
    emit      = accept && (r_cur >= RW'(2)) && (c_cur >= CW'(2));
    frame_end = (r_cur == RW'(IMG_H - 1)) && (c_cur == CW'(IMG_W - 1));
    win_nx    = '0;
    win_nx[W_TL*DATA_W +: DATA_W] = top_sr[1];
    win_nx[W_TC*DATA_W +: DATA_W] = top_sr[2];
    win_nx[W_TR*DATA_W +: DATA_W] = lb2_rd;
    win_nx[W_ML*DATA_W +: DATA_W] = mid_sr[1];
    win_nx[W_MC*DATA_W +: DATA_W] = mid_sr[2];
    win_nx[W_MR*DATA_W +: DATA_W] = lb1_rd;
    win_nx[W_BL*DATA_W +: DATA_W] = bot_sr[1];
    win_nx[W_BC*DATA_W +: DATA_W] = bot_sr[2];
    win_nx[W_BR*DATA_W +: DATA_W] = in_data;
  end

  // Raster counters; the frame wraps to (0,0) on its own, in_sof only forces a restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (c_cur == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (r_cur == RW'(IMG_H - 1)) ? '0 : r_cur + RW'(1);
      end else begin
        col <= c_cur + CW'(1);
        row <= r_cur;
      end
    end
  end

  // Column shift registers: index 0 is the oldest column, index 2 the newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        top_sr[i] <= '0;
        mid_sr[i] <= '0;
        bot_sr[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < 2; i++) begin
        top_sr[i] <= top_sr[i+1];
        mid_sr[i] <= mid_sr[i+1];
        bot_sr[i] <= bot_sr[i+1];
      end
      top_sr[2] <= lb2_rd;
      mid_sr[2] <= lb1_rd;
      bot_sr[2] <= in_data;
    end
  end

  // Output register: load on a completing accept, clear after a transfer, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_win   <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_last  <= frame_end;
      out_win   <= win_nx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
